// File: rtl/tick_slot_scheduler.sv
// tick_slot_scheduler
// Buffers router packets in SLOTS circular per-tick queues addressed relative to
// the current tick. Each rising edge of the global tick advances the tick pointer
// and flushes whatever is still queued for the expiring tick, counting the drops.
// Packets of the current tick are issued to the neuron controller one at a time.
// Issue is paced by the cycle count carried in the payload.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and ready
// are high. in_ready is combinational from in_pkt (its delay field), the registered
// tick pointer and the tick edge. out_valid/out_pkt are registered. Once out_valid
// is high, out_valid and out_pkt stay stable until out_ready is seen.
module tick_slot_scheduler #(
    parameter int PKT_SIZE   = 32,
    parameter int SLOTS      = 16,
    parameter int SLOT_DEPTH = 16,
    parameter int CNT_W      = 8,
    parameter int DROP_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 tick,
    input  logic [PKT_SIZE-1:0]                  in_pkt,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [PKT_SIZE-$clog2(SLOTS)-1:0]    out_pkt,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    input  logic                                 ctrl_abort,
    output logic [$clog2(SLOTS)-1:0]             cur_tick,
    output logic [DROP_W-1:0]                    drop_cnt
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int PAY_W  = PKT_SIZE - SLOT_W;
    localparam int PTR_W  = $clog2(SLOT_DEPTH);
    localparam int CNT_QW = PTR_W + 1;

    // Read-side FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    // Tick tracking
    logic                  r_tick_q;
    logic [SLOT_W-1:0]     r_tick_ptr;

    // Slot queues: payload storage plus per-slot pointers and occupancy
    logic [PAY_W-1:0]      r_mem   [SLOTS][SLOT_DEPTH];
    logic [PTR_W-1:0]      r_head  [SLOTS];
    logic [PTR_W-1:0]      r_tail  [SLOTS];
    logic [CNT_QW-1:0]     r_count [SLOTS];

    // Issue FSM and outputs
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_out_valid;
    logic [PAY_W-1:0]      r_out_pkt;
    logic [DROP_W-1:0]     r_drop_cnt;

    // Combinational control
    logic                  w_tick_edge;
    logic [SLOT_W-1:0]     w_delay;
    logic [SLOT_W-1:0]     w_target;
    logic                  w_target_full;
    logic                  w_push;
    logic                  w_cur_empty;
    logic                  w_pop;
    logic [PAY_W-1:0]      w_head_pkt;
    logic [CNT_W-1:0]      w_issue_cnt;
    logic [DROP_W:0]       w_drop_sum;
    logic [SLOTS-1:0]      w_push_vec;
    logic [SLOTS-1:0]      w_pop_vec;
    logic [SLOTS-1:0]      w_flush_vec;

    assign w_tick_edge   = tick & ~r_tick_q;
    assign w_delay       = in_pkt[PKT_SIZE-1 -: SLOT_W];
    // Target slot wraps naturally because SLOTS is a power of two
    assign w_target      = r_tick_ptr + w_delay;
    assign w_target_full = (r_count[w_target] == CNT_QW'(SLOT_DEPTH));
    // No pushes at all on a tick edge, so the slot being flushed is never written
    assign in_ready      = ~w_target_full & ~w_tick_edge;
    assign w_push        = in_valid & in_ready;

    assign w_cur_empty   = (r_count[r_tick_ptr] == '0);
    // Pop is suppressed on a tick edge so a flush and a pop never coincide
    assign w_pop         = (r_state == ST_IDLE) & ~w_cur_empty & ~w_tick_edge;
    assign w_head_pkt    = r_mem[r_tick_ptr][r_head[r_tick_ptr]];
    assign w_issue_cnt   = r_out_pkt[CNT_W-1:0];

    // Drop accumulator with one extra bit to detect saturation
    assign w_drop_sum    = {1'b0, r_drop_cnt} + (DROP_W+1)'(r_count[r_tick_ptr]);

    assign out_pkt   = r_out_pkt;
    assign out_valid = r_out_valid;
    assign cur_tick  = r_tick_ptr;
    assign drop_cnt  = r_drop_cnt;

    // Decode push, pop and flush into per-slot strobes
    always_comb begin
        w_push_vec  = '0;
        w_pop_vec   = '0;
        w_flush_vec = '0;
        for (int s = 0; s < SLOTS; s++) begin
            w_push_vec[s]  = w_push      && (w_target   == SLOT_W'(s));
            w_pop_vec[s]   = w_pop       && (r_tick_ptr == SLOT_W'(s));
            w_flush_vec[s] = w_tick_edge && (r_tick_ptr == SLOT_W'(s));
        end
    end

    // Tick edge detection and tick pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_q   <= 1'b0;
            r_tick_ptr <= '0;
        end else begin
            r_tick_q <= tick;
            if (w_tick_edge) begin
                r_tick_ptr <= r_tick_ptr + SLOT_W'(1);
            end
        end
    end

    // Per-slot head/tail/count; a flush empties the slot in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                r_head[s]  <= '0;
                r_tail[s]  <= '0;
                r_count[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_flush_vec[s]) begin
                    r_head[s]  <= r_tail[s];
                    r_count[s] <= '0;
                end else begin
                    if (w_push_vec[s]) begin
                        r_tail[s] <= r_tail[s] + PTR_W'(1);
                    end
                    if (w_pop_vec[s]) begin
                        r_head[s] <= r_head[s] + PTR_W'(1);
                    end
                    // Simultaneous push and pop leave the occupancy unchanged
                    if (w_push_vec[s] && !w_pop_vec[s]) begin
                        r_count[s] <= r_count[s] + CNT_QW'(1);
                    end else if (!w_push_vec[s] && w_pop_vec[s]) begin
                        r_count[s] <= r_count[s] - CNT_QW'(1);
                    end
                end
            end
        end
    end

    // Payload storage; only the payload is kept, the delay field is consumed by addressing
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_target][r_tail[w_target]] <= in_pkt[PAY_W-1:0];
        end
    end

    // Saturating count of packets discarded by tick flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_tick_edge) begin
            if (w_drop_sum[DROP_W]) begin
                r_drop_cnt <= '1;
            end else begin
                r_drop_cnt <= w_drop_sum[DROP_W-1:0];
            end
        end
    end

    // Issue FSM: pop the current slot, hold until taken, then pace by cycle count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_pkt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_out_pkt   <= w_head_pkt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A popped packet survives tick edges; abort has no effect here
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= w_issue_cnt;
                        r_state     <= (w_issue_cnt == '0) ? ST_IDLE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (ctrl_abort || (r_cnt == CNT_W'(1))) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_slot_scheduler.sv
// Bench for tick_slot_scheduler: small geometry (8 slots x 4 entries, 4-bit drop
// counter) so wrap, full-slot and saturation corners are reachable quickly.
module tb_tick_slot_scheduler;

    localparam int PKT = 32;
    localparam int SL  = 8;
    localparam int SW  = 3;
    localparam int DEP = 4;
    localparam int CW  = 8;
    localparam int DW  = 4;
    localparam int PAY = PKT - SW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic [PKT-1:0]  in_pkt = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PAY-1:0]  out_pkt;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            ctrl_abort = 1'b0;
    logic [SW-1:0]   cur_tick;
    logic [DW-1:0]   drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tick = 0;

    logic [PAY-1:0] exp_q[$];

    typedef struct {
        int   delay;
        int   tag;
        logic exp_rdy;
    } vec_t;

    vec_t vecs[9];
    int   flush_n[5];

    tick_slot_scheduler #(
        .PKT_SIZE  (PKT),
        .SLOTS     (SL),
        .SLOT_DEPTH(DEP),
        .CNT_W     (CW),
        .DROP_W    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_abort(ctrl_abort),
        .cur_tick  (cur_tick),
        .drop_cnt  (drop_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [PKT-1:0] mk(input int d, input int tag, input int c);
        logic [PKT-1:0] p;
        p = '0;
        p[PKT-1 -: SW] = d[SW-1:0];
        p[PAY-1:CW]    = tag[PAY-CW-1:0];
        p[CW-1:0]      = c[CW-1:0];
        return p;
    endfunction

    // Called at posedge+1; drives one offer for a cycle, returns at next posedge+1
    task automatic push(input logic [PKT-1:0] p, input logic exp_rdy, input logic track);
        in_pkt   = p;
        in_valid = 1'b1;
        #1;
        check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
        if (exp_rdy && track) exp_q.push_back(p[PAY-1:0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        exp_tick = (exp_tick + 1) % SL;
        check("cur_tick", 64'(cur_tick), 64'(exp_tick));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Scoreboard: every accepted output must match the next expected payload;
    // a held output must stay stable until taken
    logic           held = 1'b0;
    logic [PAY-1:0] held_pkt = '0;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_pkt", 64'(out_pkt), 64'(held_pkt));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", out_pkt);
                end else begin
                    check("out_pkt", 64'(out_pkt), 64'(exp_q.pop_front()));
                end
            end
            held     = out_valid && !out_ready;
            held_pkt = out_pkt;
        end
    end

    initial begin
        int n;
        int e;
        logic [PKT-1:0] pk;

        vecs[0] = '{0, 100, 1'b1};
        vecs[1] = '{1, 101, 1'b1};
        vecs[2] = '{1, 102, 1'b1};
        vecs[3] = '{1, 103, 1'b1};
        vecs[4] = '{1, 104, 1'b1};
        vecs[5] = '{1, 105, 1'b0};
        vecs[6] = '{2, 106, 1'b1};
        vecs[7] = '{3, 107, 1'b1};
        vecs[8] = '{7, 108, 1'b1};
        flush_n = '{0, 4, 4, 4, 4};

        // Reset
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_pkt", 64'(out_pkt), 64'd0);
        check("rst_cur_tick", 64'(cur_tick), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // 1: issue latency and pacing by cnt=3; second push coincides with the first pop
        out_ready = 1'b1;
        push(mk(0, 1, 3), 1'b1, 1'b1);
        push(mk(0, 2, 0), 1'b1, 1'b1);
        check("t1_issue_latency", {63'b0, out_valid}, 64'd1);
        step(1);
        wait_valid(n);
        check("t1_pace_cycles", 64'(n), 64'd4);
        step(3);

        // 2: delay 2 waits for two tick edges
        push(mk(2, 3, 0), 1'b1, 1'b1);
        step(5);
        check("t2_wait0", {63'b0, out_valid}, 64'd0);
        do_tick();
        step(4);
        check("t2_wait1", {63'b0, out_valid}, 64'd0);
        do_tick();
        wait_valid(n);
        check("t2_issue", {63'b0, out_valid}, 64'd1);
        check("t2_cur_tick", 64'(cur_tick), 64'd2);
        step(3);

        // 3: fill slot ptr+1, others still accepted
        for (int i = 0; i < 9; i++) begin
            push(mk(vecs[i].delay, vecs[i].tag, 0), vecs[i].exp_rdy, 1'b1);
        end
        repeat (7) begin
            do_tick();
            step(14);
        end
        check("t3_drained", 64'(exp_q.size()), 64'd0);
        check("t3_no_drops", 64'(drop_cnt), 64'd0);

        // 4: held packet survives a tick edge, the two queued behind it are dropped
        out_ready = 1'b0;
        push(mk(0, 110, 0), 1'b1, 1'b1);
        push(mk(0, 111, 0), 1'b1, 1'b0);
        push(mk(0, 112, 0), 1'b1, 1'b0);
        step(2);
        check("t4_held_before", {63'b0, out_valid}, 64'd1);
        do_tick();
        check("t4_drop_cnt", 64'(drop_cnt), 64'd2);
        check("t4_held_after", {63'b0, out_valid}, 64'd1);
        pk = mk(0, 110, 0);
        check("t4_held_pkt", 64'(out_pkt), 64'(pk[PAY-1:0]));
        out_ready = 1'b1;
        step(3);

        // Drop counter saturation: four full slots flushed while one packet is held
        out_ready = 1'b0;
        push(mk(0, 120, 0), 1'b1, 1'b1);
        for (int d = 1; d <= 4; d++) begin
            for (int k = 0; k < DEP; k++) begin
                push(mk(d, 121 + d * 4 + k, 0), 1'b1, 1'b0);
            end
        end
        step(1);
        e = 2;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            e = e + flush_n[i];
            if (e > 15) e = 15;
            check("sat_drop_cnt", 64'(drop_cnt), 64'(e));
        end
        out_ready = 1'b1;
        step(3);

        // 5: abort releases pacing early
        push(mk(0, 130, 200), 1'b1, 1'b1);
        push(mk(0, 131, 0), 1'b1, 1'b1);
        check("t5_issue", {63'b0, out_valid}, 64'd1);
        step(6);
        check("t5_busy", {63'b0, out_valid}, 64'd0);
        ctrl_abort = 1'b1;
        step(1);
        ctrl_abort = 1'b0;
        wait_valid(n);
        check("t5_abort_latency", 64'(n + 1), 64'd2);
        step(3);

        // Abort is ignored while a packet is offered
        out_ready = 1'b0;
        push(mk(0, 132, 0), 1'b1, 1'b1);
        step(2);
        ctrl_abort = 1'b1;
        step(2);
        ctrl_abort = 1'b0;
        check("abort_in_issue", {63'b0, out_valid}, 64'd1);
        out_ready = 1'b1;
        step(3);

        // 6: delay SLOTS-1 pushes over a full wrap, then reset mid-BUSY
        for (int i = 0; i < SL; i++) begin
            push(mk(SL - 1, 140 + i, 0), 1'b1, (i < 2) ? 1'b1 : 1'b0);
            do_tick();
            step(6);
        end
        check("t6_wrap_drained", 64'(exp_q.size()), 64'd0);
        check("t6_drop_pre", 64'(drop_cnt), 64'd15);
        push(mk(0, 150, 200), 1'b1, 1'b1);
        step(4);
        check("t6_busy", {63'b0, out_valid}, 64'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("t6_rst_out_pkt", 64'(out_pkt), 64'd0);
        check("t6_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t6_rst_cur_tick", 64'(cur_tick), 64'd0);
        step(2);
        rst = 1'b0;
        exp_tick = 0;
        step(1);
        check("t6_rst_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (SL) begin
            do_tick();
            step(4);
        end
        check("t6_post_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t6_post_out_valid", {63'b0, out_valid}, 64'd0);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
